// File: rtl/pc_unit.sv
// pc_unit -- program counter with optional hardware return stack.
//
// Purpose:
//   Holds the program counter and performs one action per clock edge. The
//   strobes are prioritised trap > ret > call > mdr_we > bus_we > rel_en > inc.
//   When no strobe is asserted, val holds. All arithmetic wraps modulo 2^WIDTH.
//   The optional return stack is circular: a push onto a full stack overwrites
//   the oldest entry and sets ovf. A pop from an empty stack holds val and
//   sets unf. Both flags are sticky until clr_err. If an error event occurs in
//   the same cycle as clr_err, the flag stays set.
//
// Configuration macro:
//   PC_UNIT_STACK_EN - when defined, the return stack is built.
//                      When undefined, these behaviours apply:
//                        - call loads bus_in.
//                        - trap loads TRAP_VEC.
//                        - ret leaves val unchanged and sets unf.
//                        - depth and ovf are tied to 0.
//
// Parameters:
//   WIDTH     program counter / address width (4..32)
//   DEPTH     return-stack entries (power of two, 2..64)
//   RESET_VEC value loaded into val by reset (low WIDTH bits used)
//   TRAP_VEC  trap target (low WIDTH bits used)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   val      out  current program counter (registered)
//   bus_in   in   absolute load source, also the call target
//   bus_we   in   load val from bus_in
//   mdr_in   in   memory-data load source
//   mdr_we   in   load val from mdr_in
//   inc      in   val + 1
//   rel_en   in   val + rel_off (rel_off is two's complement)
//   rel_off  in   relative offset
//   call     in   push val+1, load bus_in
//   ret      in   pop newest entry into val
//   trap     in   push val, load TRAP_VEC
//   clr_err  in   clear ovf / unf
//   depth    out  stack occupancy 0..DEPTH
//   ovf      out  sticky overflow flag
//   unf      out  sticky underflow flag

module pc_unit #(
  parameter int          WIDTH     = 16,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_fff0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [WIDTH-1:0]       val,
  input  logic [WIDTH-1:0]       bus_in,
  input  logic                   bus_we,
  input  logic [WIDTH-1:0]       mdr_in,
  input  logic                   mdr_we,
  input  logic                   inc,
  input  logic                   rel_en,
  input  logic [WIDTH-1:0]       rel_off,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   trap,
  input  logic                   clr_err,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   ovf,
  output logic                   unf
);

  localparam logic [WIDTH-1:0] RESET_W = RESET_VEC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TRAP_W  = TRAP_VEC[WIDTH-1:0];

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_TRAP,
    ACT_RET,
    ACT_CALL,
    ACT_MDR,
    ACT_BUS,
    ACT_REL,
    ACT_INC
  } act_t;

  logic [WIDTH-1:0]        r_val;
  logic                    r_ovf;
  logic                    r_unf;

  act_t                    w_act;
  logic [WIDTH-1:0]        w_val_nxt;
  logic signed [WIDTH-1:0] w_rel_off;
  logic [WIDTH-1:0]        w_pop_val;
  logic                    w_pop_ok;
  logic                    w_ovf_evt;
  logic                    w_unf_evt;

  assign w_rel_off = rel_off;

  // Exactly one winner per cycle. Losing strobes have no side effects
  // because everything downstream keys off w_act only.
  always_comb begin
    w_act = ACT_NONE;
    if (trap)        w_act = ACT_TRAP;
    else if (ret)    w_act = ACT_RET;
    else if (call)   w_act = ACT_CALL;
    else if (mdr_we) w_act = ACT_MDR;
    else if (bus_we) w_act = ACT_BUS;
    else if (rel_en) w_act = ACT_REL;
    else if (inc)    w_act = ACT_INC;
  end

  // Next program counter. The sums are truncated to WIDTH, so they wrap.
  always_comb begin
    w_val_nxt = r_val;
    unique case (w_act)
      ACT_TRAP: w_val_nxt = TRAP_W;
      ACT_RET:  if (w_pop_ok) w_val_nxt = w_pop_val;
      ACT_CALL: w_val_nxt = bus_in;
      ACT_MDR:  w_val_nxt = mdr_in;
      ACT_BUS:  w_val_nxt = bus_in;
      ACT_REL:  w_val_nxt = WIDTH'($signed(r_val) + w_rel_off);
      ACT_INC:  w_val_nxt = r_val + WIDTH'(1);
      default:  w_val_nxt = r_val;
    endcase
  end

`ifdef PC_UNIT_STACK_EN
  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  // Entry storage is deliberately not reset. Entries are unreachable
  // while depth is 0.
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [PW-1:0]    r_top;    // next slot to write; equals oldest slot when full
  logic [DW-1:0]    r_depth;

  logic             w_push;
  logic             w_pop_req;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_push_val;
  logic [PW-1:0]    w_top_m1;

  assign w_push     = (w_act == ACT_TRAP) || (w_act == ACT_CALL);
  assign w_pop_req  = (w_act == ACT_RET);
  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_push_val = (w_act == ACT_TRAP) ? r_val : (r_val + WIDTH'(1));
  assign w_top_m1   = r_top - PW'(1);
  assign w_pop_val  = r_stack[w_top_m1];
  assign w_pop_ok   = w_pop_req && !w_empty;
  assign w_ovf_evt  = w_push && w_full;
  assign w_unf_evt  = w_pop_req && w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_top] <= w_push_val;
  end

  // The pointer wraps naturally because DEPTH is a power of two. When the
  // stack is full, a push overwrites the oldest slot and depth saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top   <= '0;
      r_depth <= '0;
    end else if (w_push) begin
      r_top <= r_top + PW'(1);
      if (!w_full) r_depth <= r_depth + DW'(1);
    end else if (w_pop_ok) begin
      r_top   <= w_top_m1;
      r_depth <= r_depth - DW'(1);
    end
  end

  assign depth = r_depth;
`else
  assign w_pop_val = '0;
  assign w_pop_ok  = 1'b0;
  assign w_ovf_evt = 1'b0;
  assign w_unf_evt = (w_act == ACT_RET);
  assign depth     = '0;
`endif

  // Program counter and sticky flags. An error event overrides clr_err
  // in the same cycle, so a coincident error is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= RESET_W;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_val <= w_val_nxt;
      r_ovf <= (r_ovf && !clr_err) || w_ovf_evt;
      r_unf <= (r_unf && !clr_err) || w_unf_evt;
    end
  end

  assign val = r_val;
  assign ovf = r_ovf;
  assign unf = r_unf;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit (WIDTH=16, DEPTH=8). Expectations for the
// return stack follow whether PC_UNIT_STACK_EN is defined for the build.
`timescale 1ns/1ps
module tb_pc_unit;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
`ifdef PC_UNIT_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] val, bus_in, mdr_in, rel_off;
  logic        bus_we, mdr_we, inc, rel_en, call, ret, trap, clr_err;
  logic [3:0]  depth;
  logic        ovf, unf;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp16;
  logic [3:0]  exp4;
  logic        exp1;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VEC(32'h0), .TRAP_VEC(32'h0000_fff0)) dut (
    .clk(clk), .rst_n(rst_n), .val(val),
    .bus_in(bus_in), .bus_we(bus_we), .mdr_in(mdr_in), .mdr_we(mdr_we),
    .inc(inc), .rel_en(rel_en), .rel_off(rel_off),
    .call(call), .ret(ret), .trap(trap), .clr_err(clr_err),
    .depth(depth), .ovf(ovf), .unf(unf)
  );

  task automatic idle();
    bus_we = 0; mdr_we = 0; inc = 0; rel_en = 0; call = 0; ret = 0; trap = 0; clr_err = 0;
    bus_in = '0; mdr_in = '0; rel_off = '0;
  endtask

  // One active edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [15:0] v);
    bus_in = v; bus_we = 1; cycle(); bus_we = 0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (val !== 16'h0000) begin errors++; $display("FAIL reset_val val=%h exp=0000", val); end
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth depth=%0d exp=0", depth); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf ovf=%b exp=0", ovf); end
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL reset_unf unf=%b exp=0", unf); end
    rst_n = 1;
  endtask

  task automatic test_inc();
    inc = 1;
    for (int i = 1; i <= 3; i++) begin
      cycle(); exp16 = 16'(i);
      checks++; if (val !== exp16) begin errors++; $display("FAIL inc_%0d val=%h exp=%h", i, val, exp16); end
    end
    inc = 0;
    load(16'hffff);
    checks++; if (val !== 16'hffff) begin errors++; $display("FAIL load_ffff val=%h exp=ffff", val); end
    inc = 1; cycle(); inc = 0;
    checks++; if (val !== 16'h0000) begin errors++; $display("FAIL inc_wrap val=%h exp=0000", val); end
  endtask

  task automatic test_rel();
    load(16'h0100);
    rel_en = 1; rel_off = 16'hfffe; cycle(); rel_en = 0;
    checks++; if (val !== 16'h00fe) begin errors++; $display("FAIL rel_neg val=%h exp=00fe", val); end
    load(16'h0100);
    rel_en = 1; rel_off = 16'h0010; cycle(); rel_en = 0;
    checks++; if (val !== 16'h0110) begin errors++; $display("FAIL rel_pos val=%h exp=0110", val); end
  endtask

  task automatic test_priority();
    load(16'h0200);
    mdr_in = 16'h1234; mdr_we = 1; bus_in = 16'h5678; bus_we = 1; rel_en = 1; rel_off = 16'h0004; inc = 1;
    cycle();
    checks++; if (val !== 16'h1234) begin errors++; $display("FAIL prio_mdr val=%h exp=1234", val); end
    mdr_we = 0; cycle();
    checks++; if (val !== 16'h5678) begin errors++; $display("FAIL prio_bus val=%h exp=5678", val); end
    bus_we = 0; cycle();
    checks++; if (val !== 16'h567c) begin errors++; $display("FAIL prio_rel val=%h exp=567c", val); end
    rel_en = 0; cycle();
    checks++; if (val !== 16'h567d) begin errors++; $display("FAIL prio_inc val=%h exp=567d", val); end
    inc = 0; cycle();
    checks++; if (val !== 16'h567d) begin errors++; $display("FAIL hold val=%h exp=567d", val); end
  endtask

  task automatic test_call_ret();
    load(16'h0020);
    call = 1; bus_in = 16'h0400; cycle(); call = 0;
    checks++; if (val !== 16'h0400) begin errors++; $display("FAIL call_val val=%h exp=0400", val); end
    exp4 = STK ? 4'd1 : 4'd0;
    checks++; if (depth !== exp4) begin errors++; $display("FAIL call_depth depth=%0d exp=%0d", depth, exp4); end
    ret = 1; cycle(); ret = 0;
    exp16 = STK ? 16'h0021 : 16'h0400;
    checks++; if (val !== exp16) begin errors++; $display("FAIL ret_val val=%h exp=%h", val, exp16); end
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL ret_depth depth=%0d exp=0", depth); end
    exp1 = !STK;
    checks++; if (unf !== exp1) begin errors++; $display("FAIL ret_unf unf=%b exp=%b", unf, exp1); end
    clr_err = 1; cycle(); clr_err = 0;
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL clr_unf unf=%b exp=0", unf); end
  endtask

  task automatic test_overflow();
    load(16'h0010);
    for (int i = 0; i < 9; i++) begin
      bus_in = 16'(16'h0011 + i); call = 1; cycle();
    end
    call = 0;
    checks++; if (val !== 16'h0019) begin errors++; $display("FAIL ovf_val val=%h exp=0019", val); end
    exp4 = STK ? 4'd8 : 4'd0;
    checks++; if (depth !== exp4) begin errors++; $display("FAIL ovf_depth depth=%0d exp=%0d", depth, exp4); end
    exp1 = STK;
    checks++; if (ovf !== exp1) begin errors++; $display("FAIL ovf_flag ovf=%b exp=%b", ovf, exp1); end
    for (int i = 0; i < 8; i++) begin
      ret = 1; cycle();
      exp16 = STK ? 16'(16'h0019 - i) : 16'h0019;
      checks++; if (val !== exp16) begin errors++; $display("FAIL pop_%0d val=%h exp=%h", i, val, exp16); end
    end
    cycle(); ret = 0;
    exp16 = STK ? 16'h0012 : 16'h0019;
    checks++; if (val !== exp16) begin errors++; $display("FAIL pop_empty val=%h exp=%h", val, exp16); end
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL pop_depth depth=%0d exp=0", depth); end
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL pop_unf unf=%b exp=1", unf); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      bus_in = 16'(16'h0030 + i); call = 1; cycle();
    end
    call = 0;
    exp4 = STK ? 4'd3 : 4'd0;
    checks++; if (depth !== exp4) begin errors++; $display("FAIL pre_rst_depth depth=%0d exp=%0d", depth, exp4); end
    exp1 = STK;
    checks++; if (ovf !== exp1) begin errors++; $display("FAIL pre_rst_ovf ovf=%b exp=%b", ovf, exp1); end
    #2 rst_n = 0;
    #1;
    checks++; if (val !== 16'h0000) begin errors++; $display("FAIL arst_val val=%h exp=0000", val); end
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL arst_depth depth=%0d exp=0", depth); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf ovf=%b exp=0", ovf); end
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL arst_unf unf=%b exp=0", unf); end
    #1 rst_n = 1;
  endtask

  task automatic test_clr_coincident();
    ret = 1; cycle();
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL unf_set unf=%b exp=1", unf); end
    clr_err = 1; cycle(); ret = 0;
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL clr_coincident unf=%b exp=1", unf); end
    cycle(); clr_err = 0;
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL clr_alone unf=%b exp=0", unf); end
  endtask

  task automatic test_trap();
    load(16'h0050);
    trap = 1; ret = 1; bus_we = 1; bus_in = 16'h1111; cycle();
    trap = 0; ret = 0; bus_we = 0;
    checks++; if (val !== 16'hfff0) begin errors++; $display("FAIL trap_val val=%h exp=fff0", val); end
    exp4 = STK ? 4'd1 : 4'd0;
    checks++; if (depth !== exp4) begin errors++; $display("FAIL trap_depth depth=%0d exp=%0d", depth, exp4); end
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL trap_no_unf unf=%b exp=0", unf); end
    ret = 1; cycle(); ret = 0;
    exp16 = STK ? 16'h0050 : 16'hfff0;
    checks++; if (val !== exp16) begin errors++; $display("FAIL trap_ret val=%h exp=%h", val, exp16); end
    clr_err = 1; cycle(); clr_err = 0;
  endtask

  task automatic test_reset_midcall();
    call = 1; bus_in = 16'h0777;
    #2 rst_n = 0;
    @(posedge clk); #1;
    checks++; if (val !== 16'h0000) begin errors++; $display("FAIL midcall_rst val=%h exp=0000", val); end
    #2 rst_n = 1;
    cycle(); call = 0;
    checks++; if (val !== 16'h0777) begin errors++; $display("FAIL midcall_resume val=%h exp=0777", val); end
    exp4 = STK ? 4'd1 : 4'd0;
    checks++; if (depth !== exp4) begin errors++; $display("FAIL midcall_depth depth=%0d exp=%0d", depth, exp4); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_rel();
    test_priority();
    test_call_ret();
    test_overflow();
    test_async_reset();
    test_clr_coincident();
    test_trap();
    test_reset_midcall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning program counter and address width in bits (4..32).
REQ-002 SHALL provide parameter DEPTH, default 8, meaning return-stack entries (power of two, 2..64).
REQ-003 SHALL provide parameter RESET_VEC, default 0, meaning val after reset.
REQ-004 SHALL provide parameter TRAP_VEC, default 16'hfff0 zero-extended or truncated to WIDTH, meaning trap target.
REQ-005 SHALL provide port clk  input  1  clock, all state updates on its rising edge.
REQ-006 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL provide port val  output  WIDTH  current program counter, registered.
REQ-008 SHALL provide port bus_in / bus_we  input  WIDTH / 1  absolute load source and strobe.
REQ-009 SHALL provide port mdr_in / mdr_we  input  WIDTH / 1  memory-data load source and strobe.
REQ-010 SHALL provide port inc  input  1  increment by one.
REQ-011 SHALL provide port rel_en / rel_off  input  1 / WIDTH  add two's-complement offset to val.
REQ-012 SHALL provide port call  input  1  push val+1, load bus_in.
REQ-013 SHALL provide port ret  input  1  pop top of stack into val.
REQ-014 SHALL provide port trap  input  1  push val, load TRAP_VEC.
REQ-015 SHALL provide port clr_err  input  1  clear ovf and unf.
REQ-016 SHALL provide port depth  output  $clog2(DEPTH)+1  current stack occupancy, 0..DEPTH.
REQ-017 SHALL provide port ovf / unf  output  1 / 1  sticky overflow / underflow flags.

Function
REQ-018 SHALL perform exactly one action per cycle, priority trap > ret > call > mdr_we > bus_we > rel_en > inc; no strobe asserted -> val holds.
REQ-019 SHALL compute all val arithmetic modulo 2^WIDTH; inc at all-ones -> 0; rel_off sign bit is bit WIDTH-1.
REQ-020 SHALL make every action visible on val the cycle after the strobing edge (latency 1), no combinational path from inputs to outputs.
REQ-021 SHALL, on push (call/trap) with depth<DEPTH, write the entry at top and increment depth.
REQ-022 SHALL, on push with depth==DEPTH, overwrite the oldest entry (circular), keep depth at DEPTH, and set ovf.
REQ-023 SHALL, on ret with depth>0, load val from the newest entry and decrement depth.
REQ-024 SHALL, on ret with depth==0, hold val, keep depth 0, and set unf.
REQ-025 SHALL treat the stack as LIFO with wrapping pointer; after overflow, DEPTH consecutive rets return the DEPTH newest pushes, newest first.
REQ-026 SHALL keep ovf/unf set until clr_err; clr_err coincident with a new error event leaves the flag set.
REQ-027 SHALL ignore lower-priority strobes entirely (no push, no flag) when a higher-priority one wins.

Reset
REQ-028 SHALL on rst_n low immediately set val=RESET_VEC, depth=0, ovf=0, unf=0, independent of clk.
REQ-029 SHALL not clear stack entry storage on reset; entries are unreachable while depth=0.
REQ-030 SHALL, when rst_n asserts mid-sequence (e.g. during call), abandon the action; first edge after deassertion uses normal priority.

Configuration
REQ-031 SHALL compile the return stack only when PC_UNIT_STACK_EN is defined.
REQ-032 SHALL, without PC_UNIT_STACK_EN, make call load bus_in without push, trap load TRAP_VEC without push, ret a no-op on val that still sets unf, depth tied 0, ovf tied 0, priority unchanged.

Verification
REQ-033 SHALL cover: reset then inc x3 with WIDTH=16 -> val 0,1,2,3; val=16'hffff + inc -> 16'h0000.
REQ-034 SHALL cover: val=16'h0100, rel_en rel_off=16'hfffe -> 16'h00fe; rel_off=16'h0010 -> 16'h0110.
REQ-035 SHALL cover: val=16'h0020, call bus_in=16'h0400 -> val 16'h0400 depth 1; ret -> val 16'h0021 depth 0.
REQ-036 SHALL cover: DEPTH=8, 9 calls from val 0x10..0x18 -> depth 8, ovf=1; 8 rets return 0x19..0x12, ninth ret holds val, unf=1.
REQ-037 SHALL cover: trap+ret+bus_we same cycle at val=16'h0050 -> val 16'hfff0, depth +1; next ret -> 16'h0050.
REQ-038 SHALL cover: rst_n pulsed low between clk edges with depth 3, ovf 1 -> val RESET_VEC, depth 0, ovf 0 before next edge.
